lcd_pattern_gen: RTL

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

---
 rtl/lcd_pattern_pkg.sv | 36 +++
 rtl/lcd_pattern_gen_cmd.sv | 70 +++++++
 rtl/lcd_pattern_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_pattern_pkg.sv
// Shared types and constants for the LCD test-pattern generator.
// The optional animation feature is controlled by the PATTERN_ANIM_EN macro
// (see lcd_pattern_gen.sv); nothing in this package depends on it.
package lcd_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_SPLIT    = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  localparam logic [1:0] OP_MODE  = 2'b00;
  localparam logic [1:0] OP_FG    = 2'b01;
  localparam logic [1:0] OP_BG    = 2'b10;
  localparam logic [1:0] OP_CHECK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FG_HI = 3'd1,
    ST_FG_LO = 3'd2,
    ST_BG_HI = 3'd3,
    ST_BG_LO = 3'd4
  } cmd_state_e;

  localparam logic [15:0] DEFAULT_FG   = 16'h07E0;
  localparam logic [15:0] DEFAULT_BG   = 16'hF800;
  localparam logic [2:0]  DEFAULT_K    = 3'd3;
  localparam mode_e       DEFAULT_MODE = MODE_CHECKER;

  // The checker bit index saturates at 7 so it always addresses an 8-bit coordinate.
  function automatic logic [2:0] clampK(input logic [5:0] v);
    return (v > 6'd7) ? 3'd7 : v[2:0];
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_cmd.sv
// Command decoder for the pattern generator: turns UART bytes into the
// mode, foreground/background colours and checker bit used by the pixel path.
// Colours arrive as two bytes; the high byte is held in a shadow register so a
// half-received colour never reaches fg/bg.
module lcd_cmd_decoder
  import lcd_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmdValid_i,
  input  logic [7:0]  cmdData_i,
  output mode_e       mode_o,
  output logic [15:0] fg_o,
  output logic [15:0] bg_o,
  output logic [2:0]  k_o
);

  cmd_state_e  state_q;
  logic [7:0]  shadow_q;
  logic [15:0] fg_q;
  logic [15:0] bg_q;
  mode_e       mode_q;
  logic [2:0]  k_q;

  // One byte per strobe; reset drops any pending shadow byte and restores defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= 8'h00;
      fg_q     <= DEFAULT_FG;
      bg_q     <= DEFAULT_BG;
      mode_q   <= DEFAULT_MODE;
      k_q      <= DEFAULT_K;
    end else if (cmdValid_i) begin
      case (state_q)
        ST_IDLE: begin
          case (cmdData_i[7:6])
            OP_MODE:  mode_q  <= mode_e'(cmdData_i[1:0]);
            OP_FG:    state_q <= ST_FG_HI;
            OP_BG:    state_q <= ST_BG_HI;
            default:  k_q     <= clampK(cmdData_i[5:0]);
          endcase
        end
        ST_FG_HI: begin
          shadow_q <= cmdData_i;
          state_q  <= ST_FG_LO;
        end
        ST_FG_LO: begin
          fg_q    <= {shadow_q, cmdData_i};
          state_q <= ST_IDLE;
        end
        ST_BG_HI: begin
          shadow_q <= cmdData_i;
          state_q  <= ST_BG_LO;
        end
        ST_BG_LO: begin
          bg_q    <= {shadow_q, cmdData_i};
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode_o = mode_q;
  assign fg_o   = fg_q;
  assign bg_o   = bg_q;
  assign k_o    = k_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator top: answers pixel colour requests one cycle
// later from the current pattern settings held by lcd_cmd_decoder.
// Macro PATTERN_ANIM_EN enables a free-running tick counter that advances the
// gradient phase; without it phase is constant zero.
module lcd_pattern_gen
  import lcd_pattern_pkg::*;
#(
  parameter int H_RES     = 160,
  parameter int V_RES     = 128,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int TICK_LOG2 = 18,
  parameter int PHASE_MAX = 150
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic [7:0]     cmd_data,
  input  logic           px_req,
  input  logic [X_W-1:0] px_x,
  input  logic [Y_W-1:0] px_y,
  output logic           px_valid,
  output logic [15:0]    px_color,
  output logic [1:0]     mode,
  output logic [7:0]     phase,
  output logic           x_edge,
  output logic           y_edge
);

  localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int CW   = (XY_W > 8) ? XY_W : 8;

  mode_e       curMode;
  logic [15:0] fg;
  logic [15:0] bg;
  logic [2:0]  k;

  lcd_cmd_decoder uCmd (
    .clk        (clk),
    .rst        (rst),
    .cmdValid_i (cmd_valid),
    .cmdData_i  (cmd_data),
    .mode_o     (curMode),
    .fg_o       (fg),
    .bg_o       (bg),
    .k_o        (k)
  );

  assign mode = curMode;

`ifdef PATTERN_ANIM_EN
  logic [TICK_LOG2-1:0] tick_q;
  logic [7:0]           phase_q;

  // Phase steps once per tick-counter wrap and wraps after PHASE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      phase_q <= 8'd0;
    end else begin
      tick_q <= tick_q + 1'b1;
      if (&tick_q) begin
        phase_q <= (phase_q == 8'(PHASE_MAX)) ? 8'd0 : phase_q + 8'd1;
      end
    end
  end

  assign phase = phase_q;
`else
  assign phase = 8'd0;
`endif

  logic [CW-1:0] xExt;
  logic [CW-1:0] yExt;
  logic [5:0]    gradT;
  logic [15:0]   color_d;
  logic          xEdge_d;
  logic          yEdge_d;

  // Colour and edge flags for the current request, using the settings as they stand before this edge.
  always_comb begin
    xExt    = CW'(px_x);
    yExt    = CW'(px_y);
    gradT   = 6'(px_x >> 1) - phase[5:0];
    xEdge_d = int'(px_x) > (H_RES - 2);
    yEdge_d = int'(px_y) > (V_RES - 58);
    color_d = 16'h0000;
    if (int'(px_x) < H_RES && int'(px_y) < V_RES) begin
      case (curMode)
        MODE_SOLID:    color_d = fg;
        MODE_CHECKER:  color_d = (xExt[k] ^ yExt[k]) ? fg : bg;
        MODE_SPLIT:    color_d = (int'(px_x) > (H_RES / 2)) ? fg : bg;
        default:       color_d = {px_x[X_W-1 -: 5], gradT, gradT[4:0]};
      endcase
    end
  end

  logic        valid_q;
  logic [15:0] color_q;
  logic        xEdge_q;
  logic        yEdge_q;

  // Register the response; colour and edge flags hold until the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      color_q <= 16'h0000;
      xEdge_q <= 1'b0;
      yEdge_q <= 1'b0;
    end else begin
      valid_q <= px_req;
      if (px_req) begin
        color_q <= color_d;
        xEdge_q <= xEdge_d;
        yEdge_q <= yEdge_d;
      end
    end
  end

  assign px_valid = valid_q;
  assign px_color = color_q;
  assign x_edge   = xEdge_q;
  assign y_edge   = yEdge_q;

endmodule
